// File: rtl/bram_acc_pkg.sv
// Shared types and width helpers for the BRAM lane stream accessor.
// FSM state encoding plus DWIDTH_1/DWIDTH_2 derivation.
package bram_acc_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int calc_dwidth_1(input int num_lane, input int in_w);
      return num_lane * in_w;
   endfunction

   function automatic int calc_dwidth_2(input int dwidth_1);
      return 2 * dwidth_1;
   endfunction

endpackage

// File: rtl/bram_acc_lane_mul.sv
// One registered unsigned IN x IN -> 2*IN lane multiplier.
// The product register only loads on en_i so the output holds between writes.
module bram_acc_lane_mul #(
   parameter int IN_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en_i,
   input  logic [IN_W-1:0]   a_i,
   input  logic [IN_W-1:0]   b_i,
   output logic [2*IN_W-1:0] p_o
);

   logic [2*IN_W-1:0] p_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p_q <= '0;
      end else if (en_i) begin
         p_q <= {{IN_W{1'b0}}, a_i} * {{IN_W{1'b0}}, b_i};
      end
   end

   assign p_o = p_q;

endmodule

// File: rtl/bram_lane_stream_accessor.sv
// Streams words from BRAM0, scales each lane by coef, writes widened words to BRAM1.
// Optional BRAM_ACC_PERF_CNT_EN adds perf_cycles_o (cycles spent in RUN+DRAIN).
module bram_lane_stream_accessor
   import bram_acc_pkg::*;
#(
   parameter int NUM_LANE      = 4,
   parameter int IN_DATA_WIDTH = 8,
   parameter int AWIDTH        = 8,
   parameter int CNT_BIT       = AWIDTH + 1,
   parameter int RD_LAT        = 1,
   parameter int DWIDTH_1      = calc_dwidth_1(NUM_LANE, IN_DATA_WIDTH),
   parameter int DWIDTH_2      = calc_dwidth_2(DWIDTH_1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start_run_i,
   input  logic [CNT_BIT-1:0]       run_count_i,
   input  logic [IN_DATA_WIDTH-1:0] coef_i,
   input  logic [AWIDTH-1:0]        src_base_i,
   input  logic [AWIDTH-1:0]        dst_base_i,
   input  logic [DWIDTH_1-1:0]      q_b0_i,
`ifdef BRAM_ACC_PERF_CNT_EN
   output logic [31:0]              perf_cycles_o,
`endif
   output logic                     idle_o,
   output logic                     read_o,
   output logic                     write_o,
   output logic                     done_o,
   output logic [AWIDTH-1:0]        addr_b0_o,
   output logic                     ce_b0_o,
   output logic                     we_b0_o,
   output logic [AWIDTH-1:0]        addr_b1_o,
   output logic                     ce_b1_o,
   output logic                     we_b1_o,
   output logic [DWIDTH_2-1:0]      d_b1_o
);

   state_t state_q, state_d;

   logic [CNT_BIT-1:0]       cnt_q;
   logic [IN_DATA_WIDTH-1:0] coef_q;
   logic [AWIDTH-1:0]        src_q;
   logic [AWIDTH-1:0]        dst_q;
   logic [CNT_BIT-1:0]       iss_cnt_q;
   logic [CNT_BIT-1:0]       wr_cnt_q;

   logic [RD_LAT-1:0]        vld_q;
   logic [AWIDTH-1:0]        dad_q [RD_LAT];
   logic                     wr_vld_q;
   logic [AWIDTH-1:0]        wr_addr_q;

   logic start_acc;
   logic issue;
   logic last_issue;
   logic last_write;
   logic mul_en;

   assign start_acc  = (state_q == S_IDLE) && start_run_i;
   assign issue      = (state_q == S_RUN);
   assign last_issue = issue && (iss_cnt_q == cnt_q - CNT_BIT'(1));
   assign last_write = wr_vld_q && (wr_cnt_q == cnt_q - CNT_BIT'(1));
   assign mul_en     = vld_q[RD_LAT-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_run_i) state_d = (run_count_i == '0) ? S_DONE : S_RUN;
         S_RUN:   if (last_issue) state_d = S_DRAIN;
         S_DRAIN: if (last_write) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      idle_o    = (state_q == S_IDLE);
      read_o    = issue;
      done_o    = (state_q == S_DONE);
      ce_b0_o   = issue;
      addr_b0_o = issue ? (src_q + iss_cnt_q[AWIDTH-1:0]) : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q     <= '0;
         coef_q    <= '0;
         src_q     <= '0;
         dst_q     <= '0;
         iss_cnt_q <= '0;
         wr_cnt_q  <= '0;
      end else if (start_acc) begin
         cnt_q     <= run_count_i;
         coef_q    <= coef_i;
         src_q     <= src_base_i;
         dst_q     <= dst_base_i;
         iss_cnt_q <= '0;
         wr_cnt_q  <= '0;
      end else begin
         if (issue)    iss_cnt_q <= iss_cnt_q + CNT_BIT'(1);
         if (wr_vld_q) wr_cnt_q  <= wr_cnt_q + CNT_BIT'(1);
      end
   end

   // Destination address travels with the read so it lines up with q_b0_i.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q     <= '0;
         wr_vld_q  <= 1'b0;
         wr_addr_q <= '0;
         for (int i = 0; i < RD_LAT; i++) dad_q[i] <= '0;
      end else begin
         vld_q[0] <= issue;
         dad_q[0] <= dst_q + iss_cnt_q[AWIDTH-1:0];
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            dad_q[i] <= dad_q[i-1];
         end
         wr_vld_q <= mul_en;
         if (mul_en) wr_addr_q <= dad_q[RD_LAT-1];
      end
   end

   for (genvar gi = 0; gi < NUM_LANE; gi++) begin : g_lane
      bram_acc_lane_mul #(
         .IN_W (IN_DATA_WIDTH)
      ) u_mul (
         .clk   (clk),
         .reset (reset),
         .en_i  (mul_en),
         .a_i   (q_b0_i[gi*IN_DATA_WIDTH +: IN_DATA_WIDTH]),
         .b_i   (coef_q),
         .p_o   (d_b1_o[gi*2*IN_DATA_WIDTH +: 2*IN_DATA_WIDTH])
      );
   end

   assign ce_b1_o   = wr_vld_q;
   assign we_b1_o   = wr_vld_q;
   assign write_o   = wr_vld_q;
   assign addr_b1_o = wr_addr_q;
   assign we_b0_o   = 1'b0;

`ifdef BRAM_ACC_PERF_CNT_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_q <= '0;
      end else if (start_acc) begin
         perf_q <= '0;
      end else if ((state_q == S_RUN) || (state_q == S_DRAIN)) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign perf_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_bram_lane_stream_accessor.sv
// Scoreboard bench for bram_lane_stream_accessor with behavioural BRAM0/BRAM1 models.
module tb_bram_lane_stream_accessor;

   localparam int RD_LAT = 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start_run = 1'b0;
   logic [8:0]  run_count = '0;
   logic [7:0]  coef = '0;
   logic [7:0]  src_base = '0;
   logic [7:0]  dst_base = '0;
   logic [31:0] q_b0;
   logic        idle_o, read_o, write_o, done_o;
   logic [7:0]  addr_b0, addr_b1;
   logic        ce_b0, we_b0, ce_b1, we_b1;
   logic [63:0] d_b1;
`ifdef BRAM_ACC_PERF_CNT_EN
   logic [31:0] perf_cycles;
`endif

   always #5 clk = ~clk;

   bram_lane_stream_accessor #(
      .RD_LAT (RD_LAT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start_run_i (start_run),
      .run_count_i (run_count),
      .coef_i      (coef),
      .src_base_i  (src_base),
      .dst_base_i  (dst_base),
      .q_b0_i      (q_b0),
`ifdef BRAM_ACC_PERF_CNT_EN
      .perf_cycles_o (perf_cycles),
`endif
      .idle_o      (idle_o),
      .read_o      (read_o),
      .write_o     (write_o),
      .done_o      (done_o),
      .addr_b0_o   (addr_b0),
      .ce_b0_o     (ce_b0),
      .we_b0_o     (we_b0),
      .addr_b1_o   (addr_b1),
      .ce_b1_o     (ce_b1),
      .we_b1_o     (we_b1),
      .d_b1_o      (d_b1)
   );

   logic [31:0] mem0 [256];
   logic [63:0] mem1 [256];
   logic [31:0] rd_pipe [RD_LAT];
   logic [71:0] exp_q [$];

   int checks = 0;
   int errors = 0;
   int wr_cnt, ce0_cnt, ce1_cnt, done_cnt, wo_bad;
   int touched [256];

   localparam logic [63:0] SENTINEL = 64'hA5A5_5A5A_A5A5_5A5A;

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [31:0] w, input logic [7:0] c);
      logic [63:0] r;
      for (int i = 0; i < 4; i++) r[i*16 +: 16] = {8'h00, w[i*8 +: 8]} * {8'h00, c};
      return r;
   endfunction

   // BRAM0: registered read, RD_LAT cycles from ce to data
   always @(posedge clk) begin
      if (ce_b0) rd_pipe[0] <= mem0[addr_b0];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (ce_b1 && we_b1) mem1[addr_b1] <= d_b1;
   end
   assign q_b0 = rd_pipe[RD_LAT-1];

   always @(negedge clk) begin
      logic [71:0] e;
      if (write_o !== we_b1) wo_bad++;
      if (ce_b0) begin
         ce0_cnt++;
         touched[addr_b0]++;
      end
      if (ce_b1) ce1_cnt++;
      if (done_o) done_cnt++;
      if (we_b1) begin
         wr_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_write", {addr_b1, d_b1}, 72'h0);
         end else begin
            e = exp_q.pop_front();
            check("write_addr", {64'h0, addr_b1}, {64'h0, e[71:64]});
            check("write_data", {8'h0, d_b1}, {8'h0, e[63:0]});
         end
      end
   end

   task automatic clear_stats();
      wr_cnt = 0; ce0_cnt = 0; ce1_cnt = 0; done_cnt = 0; wo_bad = 0;
      for (int i = 0; i < 256; i++) touched[i] = 0;
   endtask

   task automatic start_run_t(input int n, input logic [7:0] c, input logic [7:0] s,
                              input logic [7:0] d, input bit push);
      @(negedge clk);
      run_count = 9'(n); coef = c; src_base = s; dst_base = d; start_run = 1'b1;
      if (push) begin
         for (int k = 0; k < n; k++) begin
            logic [7:0] sa, da;
            sa = s + 8'(k);
            da = d + 8'(k);
            exp_q.push_back({da, model(mem0[sa], c)});
         end
      end
      @(negedge clk);
      start_run = 1'b0;
   endtask

   task automatic wait_done(input string tag, output int cyc);
      cyc = 0;
      while (!done_o && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_timeout"}, {71'h0, (cyc < 3000)}, 72'h1);
      @(negedge clk);
      check({tag, "_idle_after"}, {71'h0, idle_o}, 72'h1);
      check({tag, "_done_pulses"}, 72'(done_cnt), 72'd1);
      check({tag, "_sb_empty"}, 72'(exp_q.size()), 72'd0);
      check({tag, "_write_o"}, 72'(wo_bad), 72'd0);
   endtask

   initial begin
      int cyc, bad;
      for (int i = 0; i < 256; i++) begin
         mem0[i] = 32'h0103_0507;
         mem1[i] = SENTINEL;
      end
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
      clear_stats();

      repeat (2) @(negedge clk);
      check("rst_idle", {71'h0, idle_o}, 72'h1);
      check("rst_flags", {68'h0, read_o, write_o, done_o, we_b0}, 72'h0);
      check("rst_ce", {69'h0, ce_b0, ce_b1, we_b1}, 72'h0);
      check("rst_addr_data", {addr_b0, d_b1}, 72'h0);
      reset = 1'b0;

      // 1: coef 1, count 4
      clear_stats();
      start_run_t(4, 8'd1, 8'h00, 8'h00, 1'b1);
      wait_done("t1", cyc);
      check("t1_writes", 72'(wr_cnt), 72'd4);
      check("t1_mem1_0", {8'h0, mem1[0]}, {8'h0, 64'h0001_0003_0005_0007});
      check("t1_mem1_3", {8'h0, mem1[3]}, {8'h0, 64'h0001_0003_0005_0007});
`ifdef BRAM_ACC_PERF_CNT_EN
      check("t1_perf", 72'(perf_cycles), 72'(4 + RD_LAT + 1));
`endif

      // 2: coef 3, src 0x10, dst 0x80, count 8
      clear_stats();
      start_run_t(8, 8'd3, 8'h10, 8'h80, 1'b1);
      wait_done("t2", cyc);
      check("t2_writes", 72'(wr_cnt), 72'd8);
      check("t2_mem1_80", {8'h0, mem1[8'h80]}, {8'h0, 64'h0003_0009_000F_0015});
      check("t2_mem1_87", {8'h0, mem1[8'h87]}, {8'h0, 64'h0003_0009_000F_0015});
      check("t2_mem1_88", {8'h0, mem1[8'h88]}, {8'h0, SENTINEL});

      // 3: full-depth wrapping run
      for (int i = 0; i < 256; i++) mem0[i] = 32'hFFFF_FFFF;
      clear_stats();
      start_run_t(256, 8'hFF, 8'hFE, 8'h00, 1'b1);
      wait_done("t3", cyc);
      check("t3_writes", 72'(wr_cnt), 72'd256);
      check("t3_reads", 72'(ce0_cnt), 72'd256);
      bad = 0;
      for (int i = 0; i < 256; i++) if (touched[i] != 1) bad++;
      check("t3_wrap_touch", 72'(bad), 72'd0);
      check("t3_mem1_ff", {8'h0, mem1[8'hFF]}, {8'h0, 64'hFE01_FE01_FE01_FE01});

      // 4: zero count
      for (int i = 0; i < 256; i++) mem0[i] = 32'h0102_0304 + 32'(i);
      clear_stats();
      start_run_t(0, 8'd7, 8'h20, 8'h40, 1'b1);
      wait_done("t4", cyc);
      check("t4_latency", {71'h0, (cyc <= 2)}, 72'h1);
      check("t4_ce", 72'(ce0_cnt + ce1_cnt), 72'd0);
`ifdef BRAM_ACC_PERF_CNT_EN
      check("t4_perf", 72'(perf_cycles), 72'd0);
`endif

      // 5: second start mid-run is ignored
      clear_stats();
      start_run_t(10, 8'd5, 8'h30, 8'h90, 1'b1);
      repeat (2) @(negedge clk);
      start_run_t(5, 8'd9, 8'h00, 8'h00, 1'b0);
      wait_done("t5", cyc);
      check("t5_writes", 72'(wr_cnt), 72'd10);

      // 6: reset during RUN, then a fresh two-word run
      clear_stats();
      start_run_t(20, 8'd2, 8'h50, 8'hA0, 1'b1);
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t6_rst_we", {70'h0, we_b1, ce_b0}, 72'h0);
         check("t6_rst_idle", {71'h0, idle_o}, 72'h1);
      end
      #2 reset = 1'b0;
      exp_q.delete();
      clear_stats();
      start_run_t(2, 8'd4, 8'h60, 8'hC0, 1'b1);
      wait_done("t6", cyc);
      check("t6_writes", 72'(wr_cnt), 72'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
